// File: rtl/sram_pkg.sv
// Shared widths, reader state encoding and default frame size for the SRAM frame store.
package sram_pkg;

  localparam int unsigned SRAM_ADDR_W = 18;
  localparam int unsigned SRAM_DATA_W = 32;

  // 640x480 8-bit pixels packed four per word.
  localparam int unsigned DEF_FRAME_WORDS = 76800;

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StDrain,
    StDone
  } rd_state_e;

endpackage

// File: rtl/sram_rd_fifo.sv
// Synchronous word FIFO between the SRAM read pipeline and the pixel unpacker.
// Push while full is accepted only when a pop happens in the same cycle.
module sram_rd_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 32
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           wdata_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wptr_q, rptr_q;
  logic [CntW-1:0]  count_q;
  logic             do_push, do_pop;

  // Pointers wrap explicitly so non-power-of-two depths work.
  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CntW'(DEPTH));
  assign count_o = count_q;
  assign rdata_o = mem_q[rptr_q];
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // Pointer and occupancy state; reset empties the FIFO.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= ptr_inc(wptr_q);
      if (do_pop)  rptr_q <= ptr_inc(rptr_q);
      count_q <= count_q + CntW'(do_push) - CntW'(do_pop);
    end
  end

  // Storage array; contents need no reset since occupancy gates every read.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/sram_frame_reader.sv
// Frame reader: fetches FRAME_WORDS words from synchronous SRAM and streams them
// out as pixel bytes, most significant byte first, under valid/ready flow control.
module sram_frame_reader
  import sram_pkg::*;
#(
  parameter int unsigned FRAME_WORDS = DEF_FRAME_WORDS,
  parameter int unsigned READ_LAT    = 2,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic                   clk_100,
  input  logic                   rst,
  input  logic                   start,
  input  logic [SRAM_ADDR_W-1:0] base_addr,
  input  logic [SRAM_DATA_W-1:0] data_sram,
  output logic [SRAM_ADDR_W-1:0] address_to_sram,
  output logic                   output_en,
  output logic                   write_en_n,
  output logic                   chip_en,
  output logic                   adv,
  output logic [3:0]             byte_en,
  output logic [7:0]             pix_data,
  output logic                   pix_valid,
  input  logic                   pix_ready,
  output logic                   busy,
  output logic                   done
);

  localparam int unsigned IssW = $clog2(FRAME_WORDS + 1);
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned LatW = $clog2(READ_LAT + 1);

  rd_state_e              state_q, state_d;
  logic [SRAM_ADDR_W-1:0] addr_q, addr_d;
  logic [IssW-1:0]        issue_cnt_q, issue_cnt_d;
  logic [READ_LAT-1:0]    pipe_q, pipe_d;
  logic [LatW-1:0]        in_flight;
  logic                   launch, credit_ok;

  logic                   fifo_push, fifo_full, fifo_empty;
  logic [CntW-1:0]        fifo_count;
  logic [SRAM_DATA_W-1:0] fifo_rdata;

  logic [SRAM_DATA_W-1:0] word_q, word_d;
  logic [1:0]             idx_q, idx_d;
  logic                   valid_q, valid_d;
  logic                   pix_fire, unpack_load, last_taken;

  // Read-only access: write, chip enable, ADV and byte lanes are tied off.
  assign write_en_n      = 1'b1;
  assign chip_en         = 1'b0;
  assign adv             = 1'b0;
  assign byte_en         = 4'b0000;
  assign address_to_sram = addr_q;

  // ---------------------------------------------------------------------------
  // Launch control
  // ---------------------------------------------------------------------------

  // Loading the address register is the launch edge. Loading base_addr on start is
  // the first launch; every later launch needs a FIFO slot that is still free once
  // all outstanding reads land, where a pop in this cycle frees one.
  assign credit_ok = (32'(fifo_count) + 32'(in_flight)) < (FIFO_DEPTH + 32'(unpack_load));
  assign launch    = ((state_q == StIdle) && start) ||
                     ((state_q == StFetch) && (issue_cnt_q < IssW'(FRAME_WORDS)) && credit_ok);

  // Next address and launch count.
  always_comb begin
    addr_d      = addr_q;
    issue_cnt_d = issue_cnt_q;
    if (state_q == StIdle) begin
      if (start) begin
        addr_d      = base_addr;
        issue_cnt_d = IssW'(1);
      end
    end else if (launch) begin
      addr_d      = addr_q + 1'b1;
      issue_cnt_d = issue_cnt_q + 1'b1;
    end
  end

  // Launch marker pipeline: bit k set means a read launched k+1 edges ago.
  always_comb begin
    pipe_d = (pipe_q << 1) | READ_LAT'(launch);
  end

  // Outstanding reads are the set bits of the marker pipeline.
  always_comb begin
    in_flight = '0;
    for (int i = 0; i < READ_LAT; i++) begin
      in_flight = in_flight + LatW'(pipe_q[i]);
    end
  end

  assign fifo_push = pipe_q[READ_LAT-1];

  // Address, launch count and marker registers.
  always_ff @(posedge clk_100) begin
    if (rst) begin
      addr_q      <= '0;
      issue_cnt_q <= '0;
      pipe_q      <= '0;
    end else begin
      addr_q      <= addr_d;
      issue_cnt_q <= issue_cnt_d;
      pipe_q      <= pipe_d;
    end
  end

  sram_rd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (SRAM_DATA_W)
  ) u_fifo (
    .clk_i   (clk_100),
    .rst_i   (rst),
    .push_i  (fifo_push),
    .wdata_i (data_sram),
    .pop_i   (unpack_load),
    .rdata_o (fifo_rdata),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // ---------------------------------------------------------------------------
  // Unpacker
  // ---------------------------------------------------------------------------

  assign pix_fire    = valid_q && pix_ready;
  // Refill when empty, or straight behind the last byte so there is no bubble.
  assign unpack_load = !fifo_empty && (!valid_q || (pix_fire && (idx_q == 2'd3)));
  assign last_taken  = !valid_q || (pix_fire && (idx_q == 2'd3));

  // Unpacker next state: hold while stalled, advance on handshake, reload from FIFO.
  always_comb begin
    word_d  = word_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    if (unpack_load) begin
      word_d  = fifo_rdata;
      idx_d   = 2'd0;
      valid_d = 1'b1;
    end else if (pix_fire) begin
      idx_d = idx_q + 2'd1;
      if (idx_q == 2'd3) valid_d = 1'b0;
    end
  end

  // Unpacker registers.
  always_ff @(posedge clk_100) begin
    if (rst) begin
      word_q  <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      word_q  <= word_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
    end
  end

  // Byte select, most significant byte first.
  always_comb begin
    pix_data = word_q[31:24];
    unique case (idx_q)
      2'd0: pix_data = word_q[31:24];
      2'd1: pix_data = word_q[23:16];
      2'd2: pix_data = word_q[15:8];
      2'd3: pix_data = word_q[7:0];
      default: pix_data = word_q[31:24];
    endcase
  end

  assign pix_valid = valid_q;

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------

  // State register.
  always_ff @(posedge clk_100) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // Next-state logic; start outside IDLE has no effect.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (start) state_d = StFetch;
      StFetch: if (issue_cnt_d == IssW'(FRAME_WORDS)) state_d = StDrain;
      StDrain: if ((in_flight == '0) && fifo_empty && last_taken) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    output_en = 1'b1;
    busy      = 1'b1;
    done      = 1'b0;
    case (state_q)
      StIdle:           busy = 1'b0;
      StFetch, StDrain: output_en = 1'b0;
      StDone:           done = 1'b1;
      default:          busy = 1'b0;
    endcase
  end

  // Every outstanding read must always have a FIFO slot reserved for it.
  a_credit: assert property (@(posedge clk_100) disable iff (rst)
    (32'(fifo_count) + 32'(in_flight)) <= FIFO_DEPTH);

  a_no_overflow: assert property (@(posedge clk_100) disable iff (rst)
    !(fifo_push && fifo_full && !unpack_load));

endmodule

// File: tb/tb_sram_frame_reader.sv
// Bench for sram_frame_reader: a 4-word instance for timing/control scenarios and a
// 64-word instance for randomised backpressure, each with its own SRAM model.
module tb_sram_frame_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic [17:0] base_addr;

  logic        a_start, a_ready, a_oe, a_we, a_ce, a_adv, a_pv, a_busy, a_done;
  logic [31:0] a_data;
  logic [17:0] a_addr, a_addr_p1;
  logic [3:0]  a_be;
  logic [7:0]  a_pd;

  logic        b_start, b_ready, b_oe, b_we, b_ce, b_adv, b_pv, b_busy, b_done;
  logic [31:0] b_data;
  logic [17:0] b_addr, b_addr_p1;
  logic [3:0]  b_be;
  logic [7:0]  b_pd;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [7:0]  a_pix[$];
  logic [17:0] a_alog[$];
  int          a_done_cnt = 0, a_fire_cyc = 0, a_done_cyc = 0;
  logic        a_busy_p = 1'b0;
  logic [17:0] a_addr_p = '0;

  logic [7:0]  b_pix[$];
  logic [17:0] b_alog[$];
  int          b_done_cnt = 0, b_viol = 0;
  logic        b_busy_p = 1'b0, b_stall_p = 1'b0;
  logic [17:0] b_addr_p = '0;
  logic [7:0]  b_pd_p = '0;

  always #5 clk = ~clk;

  sram_frame_reader #(.FRAME_WORDS(4), .READ_LAT(2), .FIFO_DEPTH(4)) u_dut4 (
    .clk_100(clk), .rst(rst), .start(a_start), .base_addr(base_addr), .data_sram(a_data),
    .address_to_sram(a_addr), .output_en(a_oe), .write_en_n(a_we), .chip_en(a_ce),
    .adv(a_adv), .byte_en(a_be), .pix_data(a_pd), .pix_valid(a_pv), .pix_ready(a_ready),
    .busy(a_busy), .done(a_done)
  );

  sram_frame_reader #(.FRAME_WORDS(64), .READ_LAT(2), .FIFO_DEPTH(4)) u_dut64 (
    .clk_100(clk), .rst(rst), .start(b_start), .base_addr(base_addr), .data_sram(b_data),
    .address_to_sram(b_addr), .output_en(b_oe), .write_en_n(b_we), .chip_en(b_ce),
    .adv(b_adv), .byte_en(b_be), .pix_data(b_pd), .pix_valid(b_pv), .pix_ready(b_ready),
    .busy(b_busy), .done(b_done)
  );

  function automatic logic [31:0] pat(input logic [17:0] a);
    return {a[7:0], a[7:0] ^ 8'h5A, a[7:0] ^ 8'hA5, ~a[7:0]};
  endfunction

  function automatic logic [7:0] exp_byte(input logic [17:0] base, input int k);
    logic [31:0] w;
    w = pat(base + 18'(k / 4));
    case (k % 4)
      0:       return w[31:24];
      1:       return w[23:16];
      2:       return w[15:8];
      default: return w[7:0];
    endcase
  endfunction

  // SRAM models: address registered on the edge after launch, data valid for the
  // following edge, giving two edges from launch to sample.
  always @(posedge clk) begin
    a_addr_p1 <= a_addr;
    b_addr_p1 <= b_addr;
    cyc       <= cyc + 1;
  end
  assign a_data = pat(a_addr_p1);
  assign b_data = pat(b_addr_p1);

  // Observers on the falling edge: byte handshakes, done pulses, new addresses.
  always @(negedge clk) begin
    if (a_pv && a_ready) begin
      a_pix.push_back(a_pd);
      a_fire_cyc <= cyc;
    end
    if (a_done) begin
      a_done_cnt <= a_done_cnt + 1;
      a_done_cyc <= cyc;
    end
    if (a_busy && (!a_busy_p || a_addr != a_addr_p)) a_alog.push_back(a_addr);
    a_busy_p <= a_busy;
    a_addr_p <= a_addr;

    if (b_pv && b_ready) b_pix.push_back(b_pd);
    if (b_done) b_done_cnt <= b_done_cnt + 1;
    if (b_busy && (!b_busy_p || b_addr != b_addr_p)) b_alog.push_back(b_addr);
    if (b_stall_p && (!b_pv || b_pd != b_pd_p)) b_viol <= b_viol + 1;
    b_busy_p  <= b_busy;
    b_addr_p  <= b_addr;
    b_stall_p <= b_pv && !b_ready;
    b_pd_p    <= b_pd;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    checks++; if (a_addr !== 18'h0) begin errors++; $display("FAIL rst_addr: got %h want 0", a_addr); end
    checks++; if (a_oe !== 1'b1) begin errors++; $display("FAIL rst_oe: got %b want 1", a_oe); end
    checks++; if (a_pd !== 8'h00) begin errors++; $display("FAIL rst_pix_data: got %h want 00", a_pd); end
    checks++; if (a_pv !== 1'b0) begin errors++; $display("FAIL rst_pix_valid: got %b want 0", a_pv); end
    checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", a_busy); end
    checks++; if (a_done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b want 0", a_done); end
    checks++; if (a_we !== 1'b1) begin errors++; $display("FAIL rst_we_n: got %b want 1", a_we); end
    checks++; if (a_ce !== 1'b0) begin errors++; $display("FAIL rst_chip_en: got %b want 0", a_ce); end
    checks++; if (a_adv !== 1'b0) begin errors++; $display("FAIL rst_adv: got %b want 0", a_adv); end
    checks++; if (a_be !== 4'h0) begin errors++; $display("FAIL rst_byte_en: got %h want 0", a_be); end
    checks++;
    if ({b_addr, b_oe, b_pd, b_pv, b_busy, b_done, b_we, b_ce, b_adv, b_be} !==
        {18'h0, 1'b1, 8'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0}) begin
      errors++;
      $display("FAIL rst_dut64: got %h/%b/%h/%b/%b/%b/%b/%b/%b/%h want 0/1/0/0/0/0/1/0/0/0",
               b_addr, b_oe, b_pd, b_pv, b_busy, b_done, b_we, b_ce, b_adv, b_be);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_basic_frame();
    int p0, al0, d0;
    logic [7:0]  got;
    logic [17:0] ga;
    p0 = a_pix.size(); al0 = a_alog.size(); d0 = a_done_cnt;
    base_addr = 18'h10; a_ready = 1'b1;
    a_start = 1'b1; step(); a_start = 1'b0;
    checks++; if (a_busy !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b want 1", a_busy); end
    checks++; if (a_oe !== 1'b0) begin errors++; $display("FAIL basic_oe: got %b want 0", a_oe); end
    checks++; if (a_addr !== 18'h10) begin errors++; $display("FAIL basic_first_addr: got %h want 10", a_addr); end
    step(); step();
    checks++; if (a_pv !== 1'b0) begin errors++; $display("FAIL basic_early_valid: got %b want 0", a_pv); end
    step();
    checks++; if (a_pv !== 1'b1) begin errors++; $display("FAIL basic_first_valid: got %b want 1", a_pv); end
    checks++; if (a_pd !== 8'h10) begin errors++; $display("FAIL basic_first_byte: got %h want 10", a_pd); end
    for (int i = 0; i < 100 && a_done_cnt == d0; i++) step();
    repeat (3) step();
    checks++; if (a_done_cnt - d0 !== 1) begin errors++; $display("FAIL basic_done_count: got %0d want 1", a_done_cnt - d0); end
    checks++; if (a_done_cyc !== a_fire_cyc + 1) begin errors++; $display("FAIL basic_done_timing: got cycle %0d want %0d", a_done_cyc, a_fire_cyc + 1); end
    checks++; if (a_pix.size() - p0 !== 16) begin errors++; $display("FAIL basic_byte_count: got %0d want 16", a_pix.size() - p0); end
    for (int k = 0; k < 16; k++) begin
      got = (p0 + k < a_pix.size()) ? a_pix[p0 + k] : 8'hxx;
      checks++;
      if (got !== exp_byte(18'h10, k)) begin
        errors++; $display("FAIL basic_byte%0d: got %h want %h", k, got, exp_byte(18'h10, k));
      end
    end
    checks++; if (a_alog.size() - al0 !== 4) begin errors++; $display("FAIL basic_addr_count: got %0d want 4", a_alog.size() - al0); end
    for (int k = 0; k < 4; k++) begin
      ga = (al0 + k < a_alog.size()) ? a_alog[al0 + k] : 18'hx;
      checks++;
      if (ga !== 18'h10 + 18'(k)) begin errors++; $display("FAIL basic_addr%0d: got %h want %h", k, ga, 18'h10 + 18'(k)); end
    end
    checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL basic_idle_after: got %b want 0", a_busy); end
  endtask

  task automatic test_backpressure();
    int p0, al0, d0, v0, bad;
    p0 = b_pix.size(); al0 = b_alog.size(); d0 = b_done_cnt; v0 = b_viol;
    base_addr = 18'h0F0; b_ready = 1'b0;
    b_start = 1'b1; step(); b_start = 1'b0;
    for (int i = 0; i < 6000 && b_done_cnt == d0; i++) begin
      b_ready = ($urandom_range(0, 99) < 30);
      step();
    end
    b_ready = 1'b1;
    repeat (3) step();
    checks++; if (b_done_cnt - d0 !== 1) begin errors++; $display("FAIL bp_done_count: got %0d want 1", b_done_cnt - d0); end
    checks++; if (b_pix.size() - p0 !== 256) begin errors++; $display("FAIL bp_byte_count: got %0d want 256", b_pix.size() - p0); end
    bad = 0;
    for (int k = 0; k < 256; k++)
      if (p0 + k >= b_pix.size() || b_pix[p0 + k] !== exp_byte(18'h0F0, k)) bad++;
    checks++; if (bad !== 0) begin errors++; $display("FAIL bp_bytes: got %0d wrong bytes want 0", bad); end
    bad = 0;
    for (int k = 0; k < 64; k++)
      if (al0 + k >= b_alog.size() || b_alog[al0 + k] !== 18'h0F0 + 18'(k)) bad++;
    checks++; if (bad !== 0 || b_alog.size() - al0 !== 64) begin
      errors++; $display("FAIL bp_addrs: got %0d wrong of %0d want 0 of 64", bad, b_alog.size() - al0);
    end
    checks++; if (b_viol - v0 !== 0) begin errors++; $display("FAIL bp_stall_hold: got %0d changes want 0", b_viol - v0); end
  endtask

  task automatic test_start_while_busy();
    int p0, al0, d0, bad;
    p0 = a_pix.size(); al0 = a_alog.size(); d0 = a_done_cnt;
    base_addr = 18'h20; a_ready = 1'b1;
    a_start = 1'b1; step(); a_start = 1'b0; step();
    base_addr = 18'h200; a_start = 1'b1; step(); a_start = 1'b0; base_addr = 18'h20;
    for (int i = 0; i < 100 && a_done_cnt == d0; i++) step();
    repeat (5) step();
    checks++; if (a_done_cnt - d0 !== 1) begin errors++; $display("FAIL swb_done_count: got %0d want 1", a_done_cnt - d0); end
    bad = 0;
    for (int k = 0; k < 16; k++)
      if (p0 + k >= a_pix.size() || a_pix[p0 + k] !== exp_byte(18'h20, k)) bad++;
    checks++; if (bad !== 0 || a_pix.size() - p0 !== 16) begin
      errors++; $display("FAIL swb_bytes: got %0d wrong of %0d want 0 of 16", bad, a_pix.size() - p0);
    end
    bad = 0;
    for (int k = 0; k < 4; k++)
      if (al0 + k >= a_alog.size() || a_alog[al0 + k] !== 18'h20 + 18'(k)) bad++;
    checks++; if (bad !== 0 || a_alog.size() - al0 !== 4) begin
      errors++; $display("FAIL swb_addrs: got %0d wrong of %0d want 0 of 4", bad, a_alog.size() - al0);
    end
    checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL swb_idle_after: got %b want 0", a_busy); end
  endtask

  task automatic test_reset_mid_frame();
    int p0, al0, d0, bad;
    p0 = a_pix.size();
    base_addr = 18'h30; a_ready = 1'b1;
    a_start = 1'b1; step(); a_start = 1'b0;
    for (int i = 0; i < 100 && a_pix.size() - p0 < 5; i++) step();
    rst = 1'b1; step();
    checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL rmf_busy: got %b want 0", a_busy); end
    checks++; if (a_pv !== 1'b0) begin errors++; $display("FAIL rmf_pix_valid: got %b want 0", a_pv); end
    rst = 1'b0; step();
    p0 = a_pix.size(); al0 = a_alog.size(); d0 = a_done_cnt;
    base_addr = 18'h0;
    a_start = 1'b1; step(); a_start = 1'b0;
    for (int i = 0; i < 100 && a_done_cnt == d0; i++) step();
    repeat (3) step();
    checks++; if (a_done_cnt - d0 !== 1) begin errors++; $display("FAIL rmf_done_count: got %0d want 1", a_done_cnt - d0); end
    bad = 0;
    for (int k = 0; k < 16; k++)
      if (p0 + k >= a_pix.size() || a_pix[p0 + k] !== exp_byte(18'h0, k)) bad++;
    checks++; if (bad !== 0 || a_pix.size() - p0 !== 16) begin
      errors++; $display("FAIL rmf_replay_bytes: got %0d wrong of %0d want 0 of 16", bad, a_pix.size() - p0);
    end
    checks++; if (a_alog.size() <= al0 || a_alog[al0] !== 18'h0) begin
      errors++; $display("FAIL rmf_replay_addr: got %0d logged want first 00000", a_alog.size() - al0);
    end
  endtask

  task automatic test_addr_wrap();
    int p0, al0, d0, bad;
    logic [17:0] want [4];
    want[0] = 18'h3FFFE; want[1] = 18'h3FFFF; want[2] = 18'h00000; want[3] = 18'h00001;
    p0 = a_pix.size(); al0 = a_alog.size(); d0 = a_done_cnt;
    base_addr = 18'h3FFFE; a_ready = 1'b1;
    a_start = 1'b1; step(); a_start = 1'b0;
    for (int i = 0; i < 100 && a_done_cnt == d0; i++) step();
    repeat (5) step();
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (al0 + k >= a_alog.size() || a_alog[al0 + k] !== want[k]) begin
        errors++; $display("FAIL wrap_addr%0d: got %0d entries want %h", k, a_alog.size() - al0, want[k]);
      end
    end
    checks++; if (a_alog.size() - al0 !== 4) begin errors++; $display("FAIL wrap_addr_count: got %0d want 4", a_alog.size() - al0); end
    checks++; if (a_addr !== 18'h00001) begin errors++; $display("FAIL wrap_final_addr: got %h want 00001", a_addr); end
    bad = 0;
    for (int k = 0; k < 16; k++)
      if (p0 + k >= a_pix.size() || a_pix[p0 + k] !== exp_byte(18'h3FFFE, k)) bad++;
    checks++; if (bad !== 0) begin errors++; $display("FAIL wrap_bytes: got %0d wrong want 0", bad); end
  endtask

  initial begin
    rst = 1'b1; base_addr = '0;
    a_start = 1'b0; a_ready = 1'b1;
    b_start = 1'b0; b_ready = 1'b1;
    test_reset();
    test_basic_frame();
    test_backpressure();
    test_start_while_busy();
    test_reset_mid_frame();
    test_addr_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
